// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling ratio, divider math,
// CPU port addresses and status register bit positions.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int OSR = 16;

   localparam logic [7:0] UART_DATA_ADDR = 8'hE8;
   localparam logic [7:0] UART_STAT_ADDR = 8'hE9;

   localparam int STAT_RDY_BIT  = 0;
   localparam int STAT_FERR_BIT = 1;
   localparam int STAT_OVR_BIT  = 2;
   localparam int STAT_BSY_BIT  = 3;

   // Rounded clocks per oversample tick, never below one.
   function automatic int div_calc(input longint clk_hz, input longint baud,
                                   input longint osr);
      longint den;
      longint d;
      den = baud * osr;
      d   = (clk_hz + den / 2) / den;
      if (d < 1) d = 1;
      return int'(d);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus bundle: serial pin, CPU read strobe and the held byte/status.
interface uart_rx_if;

   // rd is a single-cycle strobe from the I/O decoder; there is no back-pressure:
   // the receiver holds one byte plus sticky flags until rd acknowledges them.
   logic       rx;
   logic       rd;
   logic [7:0] DOUT;
   logic       rdy;
   logic       ferr;
   logic       ovr;
   logic       bsy;

   modport master (
      output rx,
      output rd,
      input  DOUT,
      input  rdy,
      input  ferr,
      input  ovr,
      input  bsy
   );

   modport slave (
      input  rx,
      input  rd,
      output DOUT,
      output rdy,
      output ferr,
      output ovr,
      output bsy
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; restart_i realigns the phase to zero.
module uart_baud_tick #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   output logic tick_o
);

   localparam int CW = (DIV < 1) ? 1 : $clog2(DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart_i || (cnt_q == LAST)) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and a
// one-byte holding register with sticky framing/overrun flags.
module uart_rx #(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200,
   parameter int OSR    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_rx_if.slave             bus,
   output uart_pkg::uart_state_e state_o
);

   import uart_pkg::*;

   localparam int DIV = div_calc(longint'(CLK_HZ), longint'(BAUD), longint'(OSR));

   logic        rx_meta_q;
   logic        rx_sync_q;
   uart_state_e state_q, state_d;
   logic [3:0]  sc_q, sc_d;
   logic [2:0]  bc_q, bc_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [7:0]  dout_q, dout_d;
   logic        v7_q, v7_d;
   logic        v8_q, v8_d;
   logic        rdy_q, rdy_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;
   logic        tick;
   logic        restart;
   logic        vote;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk       (clk),
      .rst       (rst),
      .restart_i (restart),
      .tick_o    (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= bus.rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Third vote sample is the live synced line at sc=9.
   assign vote = (v7_q & v8_q) | (v7_q & rx_sync_q) | (v8_q & rx_sync_q);

   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      bc_d    = bc_q;
      shreg_d = shreg_q;
      dout_d  = dout_q;
      v7_d    = v7_q;
      v8_d    = v8_q;
      rdy_d   = rdy_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;
      restart = 1'b0;

      if (bus.rd) begin
         rdy_d  = 1'b0;
         ferr_d = 1'b0;
         ovr_d  = 1'b0;
      end

      if (state_q == IDLE) begin
         if (!rx_sync_q) begin
            sc_d    = 4'd0;
            state_d = START;
            restart = 1'b1;
         end
      end else if (tick) begin
         sc_d = sc_q + 4'd1;
         if (sc_q == 4'd7) v7_d = rx_sync_q;
         if (sc_q == 4'd8) v8_d = rx_sync_q;
         case (state_q)
            START: begin
               if ((sc_q == 4'd9) && vote) begin
                  state_d = IDLE;
               end else if (sc_q == 4'd15) begin
                  state_d = DATA;
                  bc_d    = 3'd0;
               end
            end
            DATA: begin
               if (sc_q == 4'd9) shreg_d = {vote, shreg_q[7:1]};
               if (sc_q == 4'd15) begin
                  if (bc_q == 3'd7) state_d = STOP;
                  else              bc_d    = bc_q + 3'd1;
               end
            end
            STOP: begin
               // Decided mid stop bit so the next start edge is caught in IDLE.
               if (sc_q == 4'd9) begin
                  state_d = IDLE;
                  if (vote) begin
                     if (!rdy_q || bus.rd) begin
                        dout_d = shreg_q;
                        rdy_d  = 1'b1;
                     end else begin
                        ovr_d = 1'b1;
                     end
                  end else begin
                     ferr_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sc_q    <= 4'd0;
         bc_q    <= 3'd0;
         shreg_q <= 8'h00;
         dout_q  <= 8'h00;
         v7_q    <= 1'b0;
         v8_q    <= 1'b0;
         rdy_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
         bc_q    <= bc_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         v7_q    <= v7_d;
         v8_q    <= v8_d;
         rdy_q   <= rdy_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.DOUT = dout_q;
   assign bus.rdy  = rdy_q;
   assign bus.ferr = ferr_q;
   assign bus.ovr  = ovr_q;
   assign bus.bsy  = (state_q != IDLE);
   assign state_o  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at DIV=4 (64 clk per bit): frame table plus hand-built
// corner sequences for glitch, overrun, same-cycle read and mid-frame reset.
module tb_uart_rx;

   import uart_pkg::*;

   localparam int BAUD    = 115200;
   localparam int CLK_HZ  = 64 * BAUD;
   localparam int BIT_CLK = 64;
   localparam int FAST_BIT_CLK = 62;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       do_rd;
      logic       exp_rdy;
      logic       exp_ferr;
      logic       exp_ovr;
      logic [7:0] exp_dout;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   uart_state_e dbg_state;
   uart_rx_if   u_if ();

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   vec_t        vecs[7];
   int          lat;

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (u_if),
      .state_o (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called just after a posedge; each bit lasts bit_clk cycles.
   task automatic send_frame(input logic [7:0] data, input logic stop,
                             input int bit_clk, input int nbits);
      logic [9:0] fr;
      fr = {stop, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         u_if.rx = fr[i];
         repeat (bit_clk) @(posedge clk);
         #1;
      end
      u_if.rx = 1'b1;
   endtask

   task automatic wait_rdy(output int n);
      n = 0;
      while ((u_if.rdy !== 1'b1) && (n < 2000)) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd_pulse();
      u_if.rd = 1'b1;
      @(posedge clk);
      #1;
      u_if.rd = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
      vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF};
      vecs[5] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF};
      vecs[6] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h7E};

      u_if.rx = 1'b1;
      u_if.rd = 1'b0;
      rst     = 1'b1;
      idle(3);
      check("reset_dout", u_if.DOUT, 8'h00);
      check("reset_rdy",  u_if.rdy,  1'b0);
      check("reset_ferr", u_if.ferr, 1'b0);
      check("reset_ovr",  u_if.ovr,  1'b0);
      check("reset_bsy",  u_if.bsy,  1'b0);
      check("reset_state", 32'(dbg_state), 32'(IDLE));
      rst = 1'b0;
      idle(10);

      // Nominal frame: rdy expected 619 clk after the edge (+-1).
      fork
         send_frame(8'h55, 1'b1, BIT_CLK, 10);
         wait_rdy(lat);
      join
      check("lat_55_in_window", 32'((lat >= 618) && (lat <= 620)), 1);
      check("dout_55", u_if.DOUT, 8'h55);
      check("ferr_55", u_if.ferr, 1'b0);
      check("ovr_55",  u_if.ovr,  1'b0);
      idle(30);
      rd_pulse();
      check("rdy_after_rd_55", u_if.rdy, 1'b0);

      // Start-bit glitch of 12 clk.
      u_if.rx = 1'b0;
      idle(5);
      check("glitch_bsy_high", u_if.bsy, 1'b1);
      idle(7);
      u_if.rx = 1'b1;
      idle(40);
      check("glitch_bsy_low", u_if.bsy,  1'b0);
      check("glitch_rdy",     u_if.rdy,  1'b0);
      check("glitch_ferr",    u_if.ferr, 1'b0);
      check("glitch_ovr",     u_if.ovr,  1'b0);

      for (int i = 0; i < 7; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, BIT_CLK, 10);
         idle(80);
         exp_q.push_back(vecs[i].exp_dout);
         check($sformatf("vec%0d_rdy", i),  u_if.rdy,  vecs[i].exp_rdy);
         check($sformatf("vec%0d_ferr", i), u_if.ferr, vecs[i].exp_ferr);
         check($sformatf("vec%0d_ovr", i),  u_if.ovr,  vecs[i].exp_ovr);
         check($sformatf("vec%0d_dout", i), u_if.DOUT, exp_q.pop_front());
         if (vecs[i].do_rd) begin
            rd_pulse();
            check($sformatf("vec%0d_clr", i), {u_if.rdy, u_if.ferr, u_if.ovr}, 3'b000);
         end
      end

      // Back-to-back frames without a read: second byte overruns.
      send_frame(8'h12, 1'b1, BIT_CLK, 10);
      send_frame(8'h34, 1'b1, BIT_CLK, 10);
      idle(80);
      check("ovr_dout", u_if.DOUT, 8'h12);
      check("ovr_rdy",  u_if.rdy,  1'b1);
      check("ovr_flag", u_if.ovr,  1'b1);
      check("ovr_ferr", u_if.ferr, 1'b0);
      rd_pulse();
      check("ovr_clr", {u_if.rdy, u_if.ferr, u_if.ovr}, 3'b000);

      // rd lands on the completion cycle of the second byte (edge 640+619).
      fork
         begin
            send_frame(8'h12, 1'b1, BIT_CLK, 10);
            send_frame(8'h34, 1'b1, BIT_CLK, 10);
         end
         begin
            repeat (1258) @(posedge clk);
            #1;
            u_if.rd = 1'b1;
            @(posedge clk);
            #1;
            u_if.rd = 1'b0;
         end
      join
      idle(80);
      check("samecyc_dout", u_if.DOUT, 8'h34);
      check("samecyc_rdy",  u_if.rdy,  1'b1);
      check("samecyc_ovr",  u_if.ovr,  1'b0);

      // Reset during data bit 4.
      send_frame(8'h00, 1'b1, BIT_CLK, 5);
      idle(20);
      check("pre_reset_bsy", u_if.bsy, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_dout", u_if.DOUT, 8'h00);
      check("midrst_rdy",  u_if.rdy,  1'b0);
      check("midrst_ferr", u_if.ferr, 1'b0);
      check("midrst_ovr",  u_if.ovr,  1'b0);
      check("midrst_bsy",  u_if.bsy,  1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(100);
      check("post_rst_idle", u_if.bsy, 1'b0);

      // Frame at +3 % baud.
      fork
         send_frame(8'hC3, 1'b1, FAST_BIT_CLK, 10);
         wait_rdy(lat);
      join
      check("fast_rdy",  u_if.rdy,  1'b1);
      check("fast_dout", u_if.DOUT, 8'hC3);
      check("fast_ferr", u_if.ferr, 1'b0);
      check("fast_ovr",  u_if.ovr,  1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
